// File: rtl/case_1_mac_pkg.sv
// Shared constants and helpers for the pipelined multiply / multiply-accumulate core.
package case_1_mac_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic logic signed [63:0] range_hi(input int w, input logic is_signed);
    if (is_signed) begin
      return (64'sd1 <<< (w - 1)) - 64'sd1;
    end else begin
      return (64'sd1 <<< w) - 64'sd1;
    end
  endfunction

  function automatic logic signed [63:0] range_lo(input int w, input logic is_signed);
    if (is_signed) begin
      return -(64'sd1 <<< (w - 1));
    end else begin
      return 64'sd0;
    end
  endfunction

endpackage

// File: rtl/case_1_mac_sat.sv
// Narrows the wide exact result into the output range, flagging values that do not fit.
module case_1_mac_sat
  import case_1_mac_pkg::*;
#(
  parameter int VW        = 25,
  parameter int DW        = 12,
  parameter bit IS_SIGNED = 1'b1,
  parameter bit SATURATE  = 1'b1
) (
  input  logic signed [VW-1:0] value_s,
  output logic        [DW-1:0] narrow_s,
  output logic                 ovf_s
);

  localparam logic signed [VW-1:0] HI = VW'(range_hi(DW, IS_SIGNED));
  localparam logic signed [VW-1:0] LO = VW'(range_lo(DW, IS_SIGNED));

  logic above_s;
  logic below_s;

  // range compare and clamp/wrap select
  always_comb begin
    above_s = (value_s > HI);
    below_s = (value_s < LO);
    ovf_s   = above_s | below_s;
    if (SATURATE && above_s) begin
      narrow_s = HI[DW-1:0];
    end else if (SATURATE && below_s) begin
      narrow_s = LO[DW-1:0];
    end else begin
      narrow_s = value_s[DW-1:0];
    end
  end

endmodule

// File: rtl/case_1_mac_pipe_s.sv
// Pipelined din0*din1 core with optional accumulate, output narrowing and valid/ready back-pressure.
module case_1_mac_pipe_s
  import case_1_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 7,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 12,
  parameter bit SIGNED0    = 1'b1,
  parameter bit SIGNED1    = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  mode,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P       = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int VW      = dout_WIDTH + P + 1;
  localparam bit PSIGNED = SIGNED0 | SIGNED1;
  localparam int unused_id = ID;

  logic                   stall_s;
  logic                   adv_s;
  logic signed [P-1:0]    op0_s;
  logic signed [P-1:0]    op1_s;
  logic signed [P-1:0]    prod_s;
  logic        [P-1:0]    fprod_s;
  logic                   fmode_s;
  logic                   fclr_s;
  logic                   fvld_s;
  logic signed [VW-1:0]   prod_ext_s;
  logic signed [VW-1:0]   acc_ext_s;
  logic signed [VW-1:0]   value_s;
  logic [dout_WIDTH-1:0]  narrow_s;
  logic                   sat_ovf_s;
  logic [dout_WIDTH-1:0]  acc_r;

  assign stall_s  = out_valid & ~out_ready;
  assign adv_s    = ce & ~stall_s;
  assign in_ready = ap_rst_n & adv_s;

  // operand extension and exact product (stage-1 datapath)
  always_comb begin
    if (SIGNED0) begin
      op0_s = P'($signed(din0));
    end else begin
      op0_s = P'(din0);
    end
    if (SIGNED1) begin
      op1_s = P'($signed(din1));
    end else begin
      op1_s = P'(din1);
    end
    prod_s = op0_s * op1_s;
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign fprod_s = prod_s;
    assign fmode_s = mode;
    assign fclr_s  = acc_clr;
    assign fvld_s  = in_valid;
  end else begin : g_pipe
    logic [P-1:0] prod_r [NUM_STAGE-1];
    logic         mode_r [NUM_STAGE-1];
    logic         clr_r  [NUM_STAGE-1];
    logic         vld_r  [NUM_STAGE-1];

    // product and delay stages; valid bits travel with their data, bubbles included
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) begin
          prod_r[i] <= '0;
          mode_r[i] <= 1'b0;
          clr_r[i]  <= 1'b0;
          vld_r[i]  <= 1'b0;
        end
      end else if (adv_s) begin
        prod_r[0] <= prod_s;
        mode_r[0] <= mode;
        clr_r[0]  <= acc_clr;
        vld_r[0]  <= in_valid;
        for (int i = 1; i < NUM_STAGE - 1; i++) begin
          prod_r[i] <= prod_r[i-1];
          mode_r[i] <= mode_r[i-1];
          clr_r[i]  <= clr_r[i-1];
          vld_r[i]  <= vld_r[i-1];
        end
      end
    end

    assign fprod_s = prod_r[NUM_STAGE-2];
    assign fmode_s = mode_r[NUM_STAGE-2];
    assign fclr_s  = clr_r[NUM_STAGE-2];
    assign fvld_s  = vld_r[NUM_STAGE-2];
  end

  // exact final-stage value, wide enough that no sum can wrap
  always_comb begin
    if (PSIGNED) begin
      prod_ext_s = VW'($signed(fprod_s));
      acc_ext_s  = VW'($signed(acc_r));
    end else begin
      prod_ext_s = VW'($unsigned(fprod_s));
      acc_ext_s  = VW'($unsigned(acc_r));
    end
    if (fmode_s == MODE_MAC && !fclr_s) begin
      value_s = acc_ext_s + prod_ext_s;
    end else begin
      value_s = prod_ext_s;
    end
  end

  case_1_mac_sat #(
    .VW        (VW),
    .DW        (dout_WIDTH),
    .IS_SIGNED (PSIGNED),
    .SATURATE  (SATURATE)
  ) u_sat (
    .value_s  (value_s),
    .narrow_s (narrow_s),
    .ovf_s    (sat_ovf_s)
  );

  // final stage: registered result plus accumulator, which keeps the narrowed value
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      acc_r     <= '0;
    end else if (adv_s) begin
      out_valid <= fvld_s;
      if (fvld_s) begin
        dout <= narrow_s;
        ovf  <= sat_ovf_s;
        case (fmode_s)
          MODE_MAC: acc_r <= narrow_s;
          MODE_MUL: if (fclr_s) acc_r <= '0;
          default:  acc_r <= acc_r;
        endcase
      end
    end
  end

endmodule

// File: doc/case_1_mac_pipe_s.md
Name: case_1_mac_pipe_s

Overview:
Parametrised, pipelined successor to the combinational HLS multiplier cores. Computes din0*din1 with configurable signedness over NUM_STAGE register stages. Adds an optional multiply-accumulate mode, saturate/wrap output narrowing, an overflow flag, and valid/ready flow control with back-pressure. Instantiated by HLS-generated datapaths wherever a multi-cycle mul/MAC core is bound.

Parameters:
ID, 1, instance tag; no functional effect
NUM_STAGE, 3, register stages from input acceptance to output; legal range 1..8
din0_WIDTH, 7, operand 0 width
din1_WIDTH, 5, operand 1 width
dout_WIDTH, 12, result and accumulator width
SIGNED0, 1, 1 = din0 is two's complement
SIGNED1, 1, 1 = din1 is two's complement
SATURATE, 1, 1 = clamp out-of-range results; 0 = keep low dout_WIDTH bits (wrap)

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; 0 freezes all state
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts the beat this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
mode  in  1  0 = MUL, 1 = MAC
acc_clr  in  1  zero the accumulator before this beat is applied
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
dout  out  dout_WIDTH  result
ovf  out  1  this result's exact value was outside the dout range

Behaviour:
- Reset (async assert, sync release): all stage valid bits, accumulator, dout and ovf go to 0. A beat in flight is discarded. in_ready is 0 while reset is asserted.
- stall = out_valid & ~out_ready.
- in_ready = ce & ~stall.
- A beat is accepted when in_valid & in_ready.
- Advance condition is ce & ~stall. When it holds, every stage shifts one position; the valid bit shifts with its data. Otherwise every stage holds.
- Bubbles are not collapsed.
- Latency is exactly NUM_STAGE advancing cycles from acceptance to out_valid. Throughput is one beat per cycle when there is no stall.
- Product: P = din0_WIDTH + din1_WIDTH bits, exact. Each operand is extended per its SIGNEDx parameter. The product is signed if SIGNED0 | SIGNED1.
- The product is formed at stage 1. Stages 2..NUM_STAGE-1 are delay only. The final stage narrows and accumulates. With NUM_STAGE = 1, all of this happens in one stage.
- Final-stage exact value V is computed in dout_WIDTH + P + 1 bits:
  - MUL: V = product.
  - MAC: V = (acc_clr ? 0 : acc) + product.
- Output range is [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] if signed, else [0, 2^dout_WIDTH - 1].
- ovf = 1 if V is outside the output range, independent of SATURATE.
- dout = clamp(V) if SATURATE, else V[dout_WIDTH-1:0].
- Accumulator update, on the cycle the beat enters the final stage:
  - MAC: acc <= dout, i.e. the post-narrowing value, so saturation is sticky-clamped.
  - MUL with acc_clr = 1: acc <= 0.
  - MUL with acc_clr = 0: acc is unchanged.
- dout and ovf hold while stalled. They change only when the final stage advances.
- ce = 0 with out_valid = 1: outputs hold. A handshake completed on that same cycle is not observed.
- Simultaneous acc_clr and MAC on one beat: the clear applies first, then that beat's product is added.
- ce = 0 during reset release: state remains reset.

Decomposition:
- Package case_1_mac_pkg:
  - mode encoding constants MODE_MUL = 0, MODE_MAC = 1
  - localparam helper for the P width
  - range-limit functions for signed and unsigned
- Sub-module case_1_mac_sat: combinational narrowing of V to dout and ovf, parametrised by widths, signedness and SATURATE. Instantiated once, in the final stage.

Test Plan:
- MUL with defaults: din0 = -64, din1 = -16, out_ready = 1 -> out_valid exactly 3 cycles after acceptance, dout = 1024, ovf = 0.
- MAC: beats (-64,-16, acc_clr = 1), then (-64,-16), then (1,1) -> dout 1024, then 2047 with ovf = 1, then 2047 with ovf = 1 (V = 2048). With SATURATE = 0 the same sequence gives 1024, -2048, -2047 and ovf 0, 1, 0.
- Back-pressure: stream 6 MUL beats (k, 2) for k = 1..6 and hold out_ready = 0 for 4 cycles after the first result -> in_ready = 0 while stalled, no loss or duplication, outputs 2, 4, 6, 8, 10, 12 in order.
- ce: drop ce for 2 cycles mid-stream -> outputs, valids and accumulator frozen, ordering preserved, latency extended by exactly 2.
- Reset mid-operation: assert ap_rst_n = 0 asynchronously with 3 beats in flight and acc = 500 -> out_valid, dout, ovf and acc go to 0 immediately. After release, the first MAC beat (3,4) without acc_clr gives dout = 12.
- Unsigned config (SIGNED0 = SIGNED1 = 0): din0 = 127, din1 = 31 -> dout = 3937, ovf = 0. MAC of the same pair twice -> 4095 with ovf = 1.
